fire_dispatch_scheduler: RTL and testbench
==========================================

Name: fire_dispatch_scheduler

Overview:
- Sequences the extinguisher nozzle/motion unit across reported fire points on the n×n sensing grid.
- Classifies each sensor report against the priority submatrix window, then queues it in one of two FIFOs: priority or normal.
- Issues one target at a time over a valid/ready command handshake and waits for the unit's completion before issuing the next.
- Sits between the grid sensor front end and the extinguisher actuator. Includes starvation guard, duplicate/range filtering and done-timeout.

Parameters:
- COORD_W, 2, coordinate width (grid up to 4×4).
- DEPTH, 4, entries per FIFO (priority and normal each).
- STARVE_LIMIT, 3, maximum consecutive priority dispatches while the normal FIFO is non-empty.
- TIMEOUT, 255, cycles allowed in WAIT_DONE before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- matrix_size  in  COORD_W  max valid index on each axis.
- prio_start_x, prio_start_y, prio_end_x, prio_end_y  in  COORD_W each  inclusive priority window corners.
- fire_valid  in  1  sensor report valid.
- fire_ready  out  1  scheduler can accept a report.
- fire_x, fire_y  in  COORD_W each  reported point.
- cmd_valid  out  1  target command valid.
- cmd_ready  in  1  actuator accepts command.
- cmd_x, cmd_y  out  COORD_W each  target point.
- cmd_prio  out  1  target came from the priority FIFO.
- ext_done  in  1  single-cycle pulse: actuator finished the current target.
- busy  out  1  state != IDLE.
- prio_count, norm_count  out  clog2(DEPTH)+1 each  FIFO occupancy.
- drop_count  out  8  saturating count of rejected reports.
- timeout_err  out  1  sticky; set on any done-timeout.

Behaviour:
- Reset (reset=0, async): FIFOs emptied, state IDLE, starve_cnt=0, timer=0.
  - All outputs 0 except fire_ready, which is 1 (cmd_valid, cmd_x, cmd_y, cmd_prio, busy, counts, drop_count, timeout_err all 0).
  - Reset mid-operation discards queued and in-service targets.
- fire_ready = !(prio_full || norm_full). Registered occupancy only; never depends on fire_x/fire_y.
- Accept when fire_valid && fire_ready at a rising edge. The report is processed in this order:
  1. Range check: fire_x>matrix_size or fire_y>matrix_size → dropped, drop_count++.
  2. Duplicate check: matches any queued entry in either FIFO, or the in-service target (ISSUE/WAIT_DONE) → dropped, drop_count++.
  3. Classification: priority iff prio_start_x<=x<=prio_end_x and prio_start_y<=y<=prio_end_y (unsigned, inclusive). If start>end on an axis, the window is empty and everything is normal.
- drop_count saturates at 255.
- Window and matrix_size are sampled live. Changes affect only later arrivals; queued entries keep their class.
- Simultaneous push and pop on the same FIFO are both performed; occupancy is unchanged.
- FSM states and transitions:
  - IDLE: if either FIFO is non-empty, pop the selected entry into cmd_x/cmd_y/cmd_prio → ISSUE.
    - Selection: priority FIFO, unless (starve_cnt==STARVE_LIMIT && norm non-empty) or priority is empty.
    - starve_cnt increments on a priority pop while norm is non-empty; clears on a normal pop or whenever norm is empty.
  - ISSUE: cmd_valid=1 with cmd_* held stable. On cmd_ready → WAIT_DONE, timer=0, cmd_valid drops next cycle.
  - WAIT_DONE: timer increments each cycle.
    - ext_done → IDLE.
    - Else if timer==TIMEOUT-1 → timeout_err=1, → IDLE; the target is abandoned, not requeued.
    - ext_done and timeout in the same cycle: treated as done, no error.
- ext_done outside WAIT_DONE is ignored.
- Latency: a report accepted at edge N into an idle, empty scheduler gives cmd_valid=1 after edge N+1. After ext_done at edge M, the next cmd_valid rises after edge M+1.
- Duplicate protection on the in-service point lasts until the return to IDLE.

Test Plan:
1. Reset release, matrix_size=3, window (0,0)-(1,1), cmd_ready=1; push (1,1).
   → cmd_valid one cycle later with cmd=(1,1), cmd_prio=1, busy=1; ext_done pulse → busy=0 next cycle.
2. While (3,3) is in WAIT_DONE, push normal (3,2) then priority (0,1); send ext_done.
   → next cmd is (0,1) prio=1; after its done, cmd is (3,2) prio=0.
3. STARVE_LIMIT=3: while (3,3) is in service, push normal (2,2) then priority (0,0),(0,1),(1,0),(1,1), then complete each.
   → issue order (0,0),(0,1),(1,0),(2,2),(1,1).
4. matrix_size=2: push (3,0) → drop_count=1. Push (1,1) twice while the first is still queued → drop_count=2, prio_count=1.
   - Fill the priority FIFO to 4 → fire_ready=0.
5. TIMEOUT=16, cmd_ready=1, never pulse ext_done.
   - → timeout_err=1 and return to IDLE 16 cycles after the handshake; the queued next target is issued one cycle later.
   - timeout_err stays 1 until reset.
6. Assert reset=0 mid-WAIT_DONE with 3 entries queued.
   → cmd_valid=0, busy=0, counts=0, drop_count=0, timeout_err=0 immediately (async); no command after release.

Source files
------------

// File: rtl/fire_dispatch_scheduler_if.sv
// Report and command handshakes for the fire dispatch scheduler.
// slave: scheduler side; master: sensor front end and actuator side.
interface fire_dispatch_scheduler_if #(
  parameter int COORD_W = 2
);
  logic               fire_valid;
  logic               fire_ready;
  logic [COORD_W-1:0] fire_x;
  logic [COORD_W-1:0] fire_y;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic               cmd_prio;
  logic               ext_done;

  modport slave (
    input  fire_valid, fire_x, fire_y,
    input  cmd_ready, ext_done,
    output fire_ready, cmd_valid,
    output cmd_x, cmd_y, cmd_prio
  );

  modport master (
    output fire_valid, fire_x, fire_y,
    output cmd_ready, ext_done,
    input  fire_ready, cmd_valid,
    input  cmd_x, cmd_y, cmd_prio
  );
endinterface

// File: rtl/fire_dispatch_scheduler.sv
// Fire dispatch scheduler: filters grid fire reports into priority/normal
// FIFOs and issues one target at a time to the extinguisher unit.
// Ports: clk, reset (async, active-low); matrix_size and prio window
// corners (live config); io = report handshake (fire_*), command
// handshake (cmd_*) and ext_done; status busy, prio_count, norm_count,
// drop_count (saturating), timeout_err (sticky).
module fire_dispatch_scheduler #(
  parameter int COORD_W      = 2,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 255,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] matrix_size,
  input  logic [COORD_W-1:0] prio_start_x,
  input  logic [COORD_W-1:0] prio_start_y,
  input  logic [COORD_W-1:0] prio_end_x,
  input  logic [COORD_W-1:0] prio_end_y,
  fire_dispatch_scheduler_if.slave io,
  output logic               busy,
  output logic [CNT_W-1:0]   prio_count,
  output logic [CNT_W-1:0]   norm_count,
  output logic [7:0]         drop_count,
  output logic               timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 * COORD_W;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int TM_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t state, state_n;

  logic [ENT_W-1:0] pq_mem [DEPTH];
  logic [ENT_W-1:0] nq_mem [DEPTH];
  logic [PTR_W-1:0] pq_rd, pq_wr;
  logic [PTR_W-1:0] nq_rd, nq_wr;
  logic [DEPTH-1:0] pq_live, nq_live;

  logic [ENT_W-1:0] fire_key;
  logic [ENT_W-1:0] cmd_key;
  logic             cmd_prio_q;
  logic [SC_W-1:0]  starve;
  logic [TM_W-1:0]  timer;

  logic accept, out_range, dup_hit, drop;
  logic in_win, push_p, push_n;
  logic pop_p, pop_n, use_norm;
  logic timer_clr, timer_inc, set_err;

  assign fire_key = {io.fire_x, io.fire_y};
  assign busy     = (state != IDLE);

  assign io.fire_ready = (prio_count != CNT_W'(DEPTH))
                      && (norm_count != CNT_W'(DEPTH));
  assign io.cmd_valid  = (state == ISSUE);
  assign io.cmd_x      = cmd_key[ENT_W-1:COORD_W];
  assign io.cmd_y      = cmd_key[COORD_W-1:0];
  assign io.cmd_prio   = cmd_prio_q;

  assign accept    = io.fire_valid && io.fire_ready;
  assign out_range = (io.fire_x > matrix_size)
                  || (io.fire_y > matrix_size);

  // start > end on an axis leaves the window empty by construction
  assign in_win = (io.fire_x >= prio_start_x)
               && (io.fire_x <= prio_end_x)
               && (io.fire_y >= prio_start_y)
               && (io.fire_y <= prio_end_y);

  // A slot is live when its distance from the read pointer is below the
  // occupancy; the in-service target is covered until back in IDLE.
  always_comb begin
    pq_live = '0;
    nq_live = '0;
    dup_hit = busy && (cmd_key == fire_key);
    for (int i = 0; i < DEPTH; i++) begin
      pq_live[i] = {1'b0, PTR_W'(i) - pq_rd} < prio_count;
      nq_live[i] = {1'b0, PTR_W'(i) - nq_rd} < norm_count;
      dup_hit |= pq_live[i] && (pq_mem[i] == fire_key);
      dup_hit |= nq_live[i] && (nq_mem[i] == fire_key);
    end
  end

  assign drop   = accept && (out_range || dup_hit);
  assign push_p = accept && !drop && in_win;
  assign push_n = accept && !drop && !in_win;

  assign use_norm = (norm_count != '0)
                 && ((prio_count == '0)
                  || (starve == SC_W'(STARVE_LIMIT)));

  always_comb begin
    state_n   = state;
    pop_p     = 1'b0;
    pop_n     = 1'b0;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (use_norm) begin
          pop_n   = 1'b1;
          state_n = ISSUE;
        end else if (prio_count != '0) begin
          pop_p   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (io.cmd_ready) begin
          timer_clr = 1'b1;
          state_n   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (io.ext_done) begin
          state_n = IDLE;
        end else if (timer == TM_W'(TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_n = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_key     <= '0;
      cmd_prio_q  <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
      starve      <= '0;
      drop_count  <= '0;
    end else begin
      if (pop_n) begin
        cmd_key    <= nq_mem[nq_rd];
        cmd_prio_q <= 1'b0;
      end else if (pop_p) begin
        cmd_key    <= pq_mem[pq_rd];
        cmd_prio_q <= 1'b1;
      end
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + TM_W'(1);
      if (set_err) timeout_err <= 1'b1;
      if (norm_count == '0) starve <= '0;
      else if (pop_p)       starve <= starve + SC_W'(1);
      else if (pop_n)       starve <= '0;
      if (drop && (drop_count != 8'hff))
        drop_count <= drop_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pq_rd      <= '0;
      pq_wr      <= '0;
      nq_rd      <= '0;
      nq_wr      <= '0;
      prio_count <= '0;
      norm_count <= '0;
    end else begin
      if (push_p) pq_wr <= pq_wr + PTR_W'(1);
      if (pop_p)  pq_rd <= pq_rd + PTR_W'(1);
      if (push_n) nq_wr <= nq_wr + PTR_W'(1);
      if (pop_n)  nq_rd <= nq_rd + PTR_W'(1);
      prio_count <= prio_count + CNT_W'(push_p)
                              - CNT_W'(pop_p);
      norm_count <= norm_count + CNT_W'(push_n)
                              - CNT_W'(pop_n);
    end
  end

  // Entry storage needs no reset: liveness comes from pointers/counts.
  always_ff @(posedge clk) begin
    if (push_p) pq_mem[pq_wr] <= fire_key;
    if (push_n) nq_mem[nq_wr] <= fire_key;
  end

endmodule

// File: tb/tb_fire_dispatch_scheduler.sv
// Self-checking bench for fire_dispatch_scheduler.
// Expected commands are queued at stimulus time, compared at handshake.
module tb_fire_dispatch_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] matrix_size;
  logic [1:0] psx, psy, pex, pey;
  logic       busy;
  logic [2:0] prio_count, norm_count;
  logic [7:0] drop_count;
  logic       timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] sb [$];

  fire_dispatch_scheduler_if #(.COORD_W(2)) io();

  fire_dispatch_scheduler #(
    .COORD_W(2),
    .DEPTH(4),
    .STARVE_LIMIT(3),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .matrix_size(matrix_size),
    .prio_start_x(psx),
    .prio_start_y(psy),
    .prio_end_x(pex),
    .prio_end_y(pey),
    .io(io),
    .busy(busy),
    .prio_count(prio_count),
    .norm_count(norm_count),
    .drop_count(drop_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag,
                           input logic [31:0] act,
                           input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && io.cmd_valid && io.cmd_ready) begin
      logic [31:0] exp;
      exp = 32'hffff_ffff;
      if (sb.size() != 0) exp = {27'd0, sb.pop_front()};
      expect_eq("cmd", {27'd0, io.cmd_x, io.cmd_y, io.cmd_prio}, exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] x, input logic [1:0] y);
    io.fire_x     = x;
    io.fire_y     = y;
    io.fire_valid = 1'b1;
    tick(1);
    io.fire_valid = 1'b0;
  endtask

  task automatic exp_cmd(input logic [1:0] x, input logic [1:0] y,
                         input logic p);
    sb.push_back({x, y, p});
  endtask

  task automatic done();
    io.ext_done = 1'b1;
    tick(1);
    io.ext_done = 1'b0;
  endtask

  task automatic wait_wd();
    int n = 0;
    while (!(busy && !io.cmd_valid) && n < 40) begin
      tick(1);
      n++;
    end
    if (n >= 40) expect_eq("wait_wd_expired", n, 0);
  endtask

  initial begin
    reset         = 1'b0;
    matrix_size   = 2'd3;
    psx = 2'd0; psy = 2'd0; pex = 2'd1; pey = 2'd1;
    io.fire_valid = 1'b0;
    io.fire_x     = '0;
    io.fire_y     = '0;
    io.cmd_ready  = 1'b1;
    io.ext_done   = 1'b0;
    tick(2);
    expect_eq("rst_fire_ready", io.fire_ready, 1);
    expect_eq("rst_cmd_valid", io.cmd_valid, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_counts", {prio_count, norm_count}, 0);
    expect_eq("rst_drop", drop_count, 0);
    expect_eq("rst_err", timeout_err, 0);
    reset = 1'b1;
    tick(1);

    // 1: single priority target, latency
    exp_cmd(2'd1, 2'd1, 1'b1);
    push(2'd1, 2'd1);
    expect_eq("t1_valid_n", io.cmd_valid, 0);
    expect_eq("t1_pcount", prio_count, 1);
    tick(1);
    expect_eq("t1_valid_n1", io.cmd_valid, 1);
    expect_eq("t1_busy", busy, 1);
    tick(1);
    expect_eq("t1_valid_drop", io.cmd_valid, 0);
    expect_eq("t1_busy_wd", busy, 1);
    done();
    expect_eq("t1_idle", busy, 0);

    // 2: priority overtakes earlier normal
    exp_cmd(2'd3, 2'd3, 1'b0);
    push(2'd3, 2'd3);
    wait_wd();
    exp_cmd(2'd0, 2'd1, 1'b1);
    exp_cmd(2'd3, 2'd2, 1'b0);
    push(2'd3, 2'd2);
    push(2'd0, 2'd1);
    done();
    wait_wd();
    done();
    wait_wd();
    done();
    expect_eq("t2_empty", {prio_count, norm_count}, 0);

    // 3: starvation guard
    exp_cmd(2'd3, 2'd3, 1'b0);
    push(2'd3, 2'd3);
    wait_wd();
    push(2'd2, 2'd2);
    push(2'd0, 2'd0);
    push(2'd0, 2'd1);
    push(2'd1, 2'd0);
    push(2'd1, 2'd1);
    expect_eq("t3_pcount", prio_count, 4);
    expect_eq("t3_ncount", norm_count, 1);
    expect_eq("t3_full", io.fire_ready, 0);
    exp_cmd(2'd0, 2'd0, 1'b1);
    exp_cmd(2'd0, 2'd1, 1'b1);
    exp_cmd(2'd1, 2'd0, 1'b1);
    exp_cmd(2'd2, 2'd2, 1'b0);
    exp_cmd(2'd1, 2'd1, 1'b1);
    done();
    for (int i = 0; i < 5; i++) begin
      wait_wd();
      done();
    end

    // 4: range / duplicate filtering, full FIFO
    matrix_size = 2'd2;
    push(2'd3, 2'd0);
    expect_eq("t4_range_drop", drop_count, 1);
    expect_eq("t4_range_nopush", {prio_count, norm_count}, 0);
    exp_cmd(2'd2, 2'd2, 1'b0);
    push(2'd2, 2'd2);
    wait_wd();
    exp_cmd(2'd1, 2'd1, 1'b1);
    push(2'd1, 2'd1);
    push(2'd1, 2'd1);
    expect_eq("t4_dup_drop", drop_count, 2);
    expect_eq("t4_dup_pcount", prio_count, 1);
    push(2'd2, 2'd2);
    expect_eq("t4_insvc_drop", drop_count, 3);
    exp_cmd(2'd0, 2'd0, 1'b1);
    exp_cmd(2'd0, 2'd1, 1'b1);
    exp_cmd(2'd1, 2'd0, 1'b1);
    push(2'd0, 2'd0);
    push(2'd0, 2'd1);
    push(2'd1, 2'd0);
    expect_eq("t4_pfull", prio_count, 4);
    expect_eq("t4_not_ready", io.fire_ready, 0);
    push(2'd2, 2'd1);
    expect_eq("t4_blocked_ncount", norm_count, 0);
    expect_eq("t4_blocked_drop", drop_count, 3);
    done();
    for (int i = 0; i < 4; i++) begin
      wait_wd();
      done();
    end
    psx = 2'd2;
    exp_cmd(2'd1, 2'd1, 1'b0);
    push(2'd1, 2'd1);
    wait_wd();
    done();
    psx = 2'd0;

    // 5: done-timeout, then next target
    exp_cmd(2'd2, 2'd0, 1'b0);
    push(2'd2, 2'd0);
    begin
      int n = 0;
      while (!io.cmd_valid && n < 10) begin
        tick(1);
        n++;
      end
      expect_eq("t5_issue", io.cmd_valid, 1);
    end
    tick(1);
    expect_eq("t5_err_pre", timeout_err, 0);
    exp_cmd(2'd1, 2'd0, 1'b1);
    push(2'd1, 2'd0);
    begin
      int cyc = 1;
      while (busy && cyc < 40) begin
        tick(1);
        cyc++;
      end
      expect_eq("t5_timeout_cycles", cyc, 16);
    end
    expect_eq("t5_err", timeout_err, 1);
    expect_eq("t5_idle_valid", io.cmd_valid, 0);
    tick(1);
    expect_eq("t5_next_valid", io.cmd_valid, 1);
    tick(1);
    done();
    io.cmd_ready = 1'b0;
    exp_cmd(2'd2, 2'd1, 1'b0);
    push(2'd2, 2'd1);
    tick(2);
    done();
    expect_eq("t5_done_in_issue", io.cmd_valid, 1);
    io.cmd_ready = 1'b1;
    wait_wd();
    done();
    expect_eq("t5_err_sticky", timeout_err, 1);

    // 6: async reset mid-service
    matrix_size = 2'd3;
    exp_cmd(2'd3, 2'd3, 1'b0);
    push(2'd3, 2'd3);
    wait_wd();
    push(2'd0, 2'd0);
    push(2'd1, 2'd1);
    push(2'd2, 2'd2);
    expect_eq("t6_queued", {prio_count, norm_count}, {3'd2, 3'd1});
    reset = 1'b0;
    #1;
    expect_eq("t6_valid", io.cmd_valid, 0);
    expect_eq("t6_busy", busy, 0);
    expect_eq("t6_counts", {prio_count, norm_count}, 0);
    expect_eq("t6_drop", drop_count, 0);
    expect_eq("t6_err", timeout_err, 0);
    expect_eq("t6_ready", io.fire_ready, 1);
    #3;
    reset = 1'b1;
    tick(20);
    expect_eq("t6_still_idle", busy, 0);
    expect_eq("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
